// File: rtl/vc_regfile_stream_reader.sv
// Burst read engine: walks a combinational register-file read port one entry per
// cycle and streams the entries out through a registered val/rdy response port.
module vc_regfile_stream_reader #(
    parameter int  p_data_nbits  = 32,
    parameter int  p_num_entries = 16,
    localparam int c_addr_nbits  = $clog2(p_num_entries),
    localparam int c_count_nbits = $clog2(p_num_entries + 1)
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     req_val,
    output logic                     req_rdy,
    input  logic [c_addr_nbits-1:0]  req_base,
    input  logic [c_count_nbits-1:0] req_count,

    output logic [c_addr_nbits-1:0]  rf_read_addr,
    input  logic [p_data_nbits-1:0]  rf_read_data,

    output logic                     resp_val,
    input  logic                     resp_rdy,
    output logic [p_data_nbits-1:0]  resp_data,
    output logic                     resp_last
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] READ = 1'b1;

    logic [0:0]               r_state;
    logic [c_addr_nbits-1:0]  r_addr;
    logic [c_count_nbits-1:0] r_remaining;
    logic                     r_out_val;
    logic                     r_out_last;
    logic [p_data_nbits-1:0]  r_out_data;

    logic                     w_fire;
    logic                     w_issue;
    logic                     w_final;
    logic [c_addr_nbits-1:0]  w_addr_next;

    assign req_rdy      = (r_state == IDLE);
    assign w_fire       = req_val && req_rdy;
    // A new entry may be captured whenever the output slot is empty or draining this cycle.
    assign w_issue      = (r_state == READ) && (!r_out_val || resp_rdy);
    assign w_final      = (r_remaining == c_count_nbits'(1));
    // Wrap at the real entry count, which need not be a power of two.
    assign w_addr_next  = (r_addr == c_addr_nbits'(p_num_entries - 1))
                        ? '0 : r_addr + c_addr_nbits'(1);

    assign rf_read_addr = r_addr;
    assign resp_val     = r_out_val;
    assign resp_data    = r_out_data;
    assign resp_last    = r_out_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_out_val   <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_fire) begin
                        r_addr      <= req_base;
                        r_remaining <= req_count;
                        if (req_count != '0)
                            r_state <= READ;
                    end
                end
                READ: begin
                    if (w_issue) begin
                        r_addr      <= w_addr_next;
                        r_remaining <= r_remaining - c_count_nbits'(1);
                        if (w_final)
                            r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_issue) begin
                r_out_val  <= 1'b1;
                r_out_data <= rf_read_data;
                r_out_last <= w_final;
            end else if (r_out_val && resp_rdy) begin
                r_out_val  <= 1'b0;
            end
        end
    end

    a_req_val_known: assert property (@(posedge clk) disable iff (reset)
        !$isunknown(req_val));
    a_req_base_ok: assert property (@(posedge clk) disable iff (reset)
        w_fire |-> (!$isunknown(req_base) && (int'(req_base) < p_num_entries)));
    a_req_count_ok: assert property (@(posedge clk) disable iff (reset)
        w_fire |-> (!$isunknown(req_count) && (int'(req_count) <= p_num_entries)));
    a_resp_rdy_known: assert property (@(posedge clk) disable iff (reset)
        !$isunknown(resp_rdy));

endmodule

// File: tb/tb_vc_regfile_stream_reader.sv
// Bench for vc_regfile_stream_reader: directed timing cases plus random bursts and
// backpressure scored against a queue of expected entries built at request time.
module tb_vc_regfile_stream_reader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_val, req_rdy, resp_val, resp_rdy, resp_last;
    logic [3:0]  req_base, rf_read_addr;
    logic [4:0]  req_count;
    logic [31:0] rf_read_data, resp_data;
    logic [31:0] mem [16];

    logic        req_val6, req_rdy6, resp_val6, resp_rdy6, resp_last6;
    logic [2:0]  req_base6, rf_read_addr6, req_count6;
    logic [31:0] rf_read_data6, resp_data6;
    logic [31:0] mem6 [6];

    assign rf_read_data  = mem[rf_read_addr];
    assign rf_read_data6 = (rf_read_addr6 < 3'd6) ? mem6[rf_read_addr6] : 32'hDEAD_BEEF;

    vc_regfile_stream_reader #(.p_data_nbits(32), .p_num_entries(16)) dut (
        .clk(clk), .reset(reset),
        .req_val(req_val), .req_rdy(req_rdy), .req_base(req_base), .req_count(req_count),
        .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_data(resp_data), .resp_last(resp_last)
    );

    vc_regfile_stream_reader #(.p_data_nbits(32), .p_num_entries(6)) dut6 (
        .clk(clk), .reset(reset),
        .req_val(req_val6), .req_rdy(req_rdy6), .req_base(req_base6), .req_count(req_count6),
        .rf_read_addr(rf_read_addr6), .rf_read_data(rf_read_data6),
        .resp_val(resp_val6), .resp_rdy(resp_rdy6), .resp_data(resp_data6), .resp_last(resp_last6)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: each accepted request expands into its list of {last, data} entries.
    logic [32:0] exp_q [$];
    logic [32:0] exp_e;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_val", resp_val, 1'b1);
                check("stall_data", resp_data, prev_data);
                check("stall_last", resp_last, prev_last);
            end
            if (resp_val && resp_rdy) begin
                check("resp_pending", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    exp_e = exp_q.pop_front();
                    check("sb_data", resp_data, exp_e[31:0]);
                    check("sb_last", resp_last, exp_e[32]);
                end
            end
            if (req_val && req_rdy)
                for (int k = 0; k < int'(req_count); k++)
                    exp_q.push_back({k == int'(req_count) - 1, mem[(int'(req_base) + k) % 16]});
            prev_stall = resp_val && !resp_rdy;
            prev_data  = resp_data;
            prev_last  = resp_last;
        end
    end

    logic [6:0] rdy_pat;

    initial begin
        reset = 1'b1; req_val = 1'b0; req_base = '0; req_count = '0; resp_rdy = 1'b1;
        req_val6 = 1'b0; req_base6 = '0; req_count6 = '0; resp_rdy6 = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = 32'h100 + i;
        for (int i = 0; i < 6; i++) mem6[i] = 32'h200 + i;
        tick();
        check("rst_req_rdy", req_rdy, 1'b1);
        check("rst_addr", rf_read_addr, 4'd0);
        check("rst_val", resp_val, 1'b0);
        check("rst_data", resp_data, 32'd0);
        check("rst_last", resp_last, 1'b0);
        tick();
        reset = 1'b0;

        // Basic burst with timing checks
        req_val = 1'b1; req_base = 4'd2; req_count = 5'd4;
        check("t1_fire_rdy", req_rdy, 1'b1);
        tick();
        req_val = 1'b0;
        check("t1_addr", rf_read_addr, 4'd2);
        check("t1_busy", req_rdy, 1'b0);
        check("t1_noval", resp_val, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            check("t1_val", resp_val, 1'b1);
            check("t1_data", resp_data, 32'h102 + k);
            check("t1_last", resp_last, k == 3);
            if (k == 3) check("t1_rdy_back", req_rdy, 1'b1);
            tick();
        end
        check("t1_drained", resp_val, 1'b0);

        // Non-power-of-two wrap on the 6-entry instance
        req_val6 = 1'b1; req_base6 = 3'd4; req_count6 = 3'd4;
        tick();
        req_val6 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("t2_range", rf_read_addr6 < 3'd6, 1'b1);
            if (k < 4) check("t2_addr", rf_read_addr6, (4 + k) % 6);
            if (k > 0) begin
                check("t2_val", resp_val6, 1'b1);
                check("t2_data", resp_data6, mem6[(4 + k - 1) % 6]);
                check("t2_last", resp_last6, k == 4);
            end
            tick();
        end
        check("t2_drained", resp_val6, 1'b0);

        // Backpressure
        rdy_pat = 7'b1101001;
        req_val = 1'b1; req_base = 4'd2; req_count = 5'd4; resp_rdy = 1'b1;
        tick();
        req_val = 1'b0;
        for (int i = 0; i < 7; i++) begin
            resp_rdy = rdy_pat[i];
            tick();
        end
        resp_rdy = 1'b1;
        repeat (6) tick();
        check("t3_all_seen", exp_q.size(), 0);

        // Zero count followed by single entry
        req_val = 1'b1; req_base = 4'd0; req_count = 5'd0;
        tick();
        check("t4_zero_rdy", req_rdy, 1'b1);
        req_count = 5'd1;
        tick();
        req_val = 1'b0;
        check("t4_noresp", resp_val, 1'b0);
        tick();
        check("t4_val", resp_val, 1'b1);
        check("t4_data", resp_data, 32'h100);
        check("t4_last", resp_last, 1'b1);
        tick();
        check("t4_drained", resp_val, 1'b0);

        // Reset mid-burst
        req_val = 1'b1; req_base = 4'd0; req_count = 5'd8;
        tick();
        req_val = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_val", resp_val, 1'b0);
        check("t5_rdy", req_rdy, 1'b1);
        check("t5_addr", rf_read_addr, 4'd0);
        req_val = 1'b1; req_base = 4'd7; req_count = 5'd2;
        tick();
        req_val = 1'b0;
        tick();
        check("t5_d0", resp_data, 32'h107);
        check("t5_l0", resp_last, 1'b0);
        tick();
        check("t5_d1", resp_data, 32'h108);
        check("t5_l1", resp_last, 1'b1);
        tick();
        check("t5_drained", resp_val, 1'b0);

        // Back-to-back full bursts: one bubble between them
        req_base = 4'd0; req_count = 5'd16;
        for (int c = 0; c < 36; c++) begin
            req_val = (c == 0) || (c == 17);
            if (c == 17) check("t6_refire", req_rdy, 1'b1);
            check("t6_val", resp_val, (c >= 2 && c <= 17) || (c >= 19 && c <= 34));
            tick();
        end
        req_val = 1'b0;
        check("t6_all_seen", exp_q.size(), 0);

        // Random bursts and backpressure over random contents
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        for (int c = 0; c < 800; c++) begin
            req_val   = ($urandom_range(0, 2) == 0);
            req_base  = 4'($urandom_range(0, 15));
            req_count = 5'($urandom_range(0, 16));
            resp_rdy  = ($urandom_range(0, 3) != 0);
            tick();
        end
        req_val = 1'b0; resp_rdy = 1'b1;
        repeat (40) tick();
        check("rand_all_seen", exp_q.size(), 0);
        check("rand_idle", req_rdy, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
